// File: rtl/cla_sub_seq_if.sv
// Handshake and data bundle for the sequential borrow-lookahead subtractor.
// The master modport drives operands and out_ready; the slave modport returns the result.
interface cla_sub_seq_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf, zero
    );
endinterface

// File: rtl/cla_sub_seq.sv
// Multi-cycle subtractor: diff = a - b - bin, one 4-bit borrow-lookahead slice per clock,
// LSB slice first, with the inter-slice borrow held in a register.
module cla_sub_seq #(
    parameter int unsigned WIDTH = 16
) (
    input logic         clk,
    input logic         rst,
    cla_sub_seq_if.slave bus
);
    localparam int unsigned NSLICE = WIDTH / 4;
    localparam int unsigned KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, res_q, diff_q;
    logic             br_q, bout_q, ovf_q, zero_q, out_valid_q;
    logic [KW-1:0]    k_q;

    logic [3:0]       sa, sb, g, p, sd;
    logic [4:0]       c;
    logic [WIDTH-1:0] res_nxt;
    logic             last, ovf_nxt;

    always_comb begin
        sa = a_q[4*k_q +: 4];
        sb = b_q[4*k_q +: 4];
        g  = ~sa & sb;
        p  = ~(sa ^ sb);
        // Fully expanded lookahead: every borrow depends only on g, p and the slice borrow-in.
        c[0] = br_q;
        c[1] = g[0] | (p[0] & br_q);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & br_q);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & br_q);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & br_q);
        sd   = sa ^ sb ^ c[3:0];
        res_nxt              = res_q;
        res_nxt[4*k_q +: 4]  = sd;
        last    = (int'(k_q) == int'(NSLICE) - 1);
        ovf_nxt = (a_q[WIDTH-1] != b_q[WIDTH-1]) & (res_nxt[WIDTH-1] != a_q[WIDTH-1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            br_q        <= 1'b0;
            k_q         <= '0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        br_q    <= bus.bin;
                        k_q     <= '0;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    res_q <= res_nxt;
                    br_q  <= c[4];
                    k_q   <= k_q + 1'b1;
                    if (last) begin
                        diff_q      <= res_nxt;
                        bout_q      <= c[4];
                        ovf_q       <= ovf_nxt;
                        zero_q      <= (res_nxt == '0);
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == StIdle) & ~rst;
    assign bus.out_valid = out_valid_q;
    assign bus.diff      = diff_q;
    assign bus.bout      = bout_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_cla_sub_seq.sv
// Self-checking bench for cla_sub_seq: directed literal cases plus randomized traffic
// checked every cycle against an arithmetic reference model.
module tb_cla_sub_seq;
    localparam int W  = 16;
    localparam int NS = W / 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rnd_mode = 1'b0;
    always #5 clk = ~clk;

    cla_sub_seq_if #(.WIDTH(W)) bus ();
    cla_sub_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Returns {ovf, zero, bout, diff} from plain unsigned and signed arithmetic.
    function automatic logic [W+2:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic bi);
        logic [W:0] full;
        int         s;
        logic       o;
        full = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
        s    = int'($signed(x)) - int'($signed(y)) - int'(bi);
        o    = (s > (2 ** (W - 1)) - 1) || (s < -(2 ** (W - 1)));
        return {o, (full[W-1:0] == '0), full[W], full[W-1:0]};
    endfunction

    // Reference model: phase 0 idle, 1 computing (lat edges since accept), 2 holding result.
    int             ph = 0;
    int             lat = 0;
    logic           mvalid = 1'b0;
    logic [W+2:0]   pend = '0;
    logic [W+2:0]   mout = '0;

    always @(posedge clk) begin
        if (rst) begin
            ph     <= 0;
            mvalid <= 1'b0;
            mout   <= '0;
        end else if (ph == 0) begin
            if (bus.in_valid) begin
                pend <= ref_sub(bus.a, bus.b, bus.bin);
                lat  <= 1;
                ph   <= 1;
            end
        end else if (ph == 1) begin
            if (lat == NS) begin
                mout   <= pend;
                mvalid <= 1'b1;
                ph     <= 2;
            end else begin
                lat <= lat + 1;
            end
        end else if (bus.out_ready) begin
            mvalid <= 1'b0;
            ph     <= 0;
        end
    end

    always @(negedge clk) begin
        chk("in_ready", 32'(bus.in_ready), 32'(ph == 0 && !rst));
        chk("out_valid", 32'(bus.out_valid), 32'(mvalid));
        chk("diff", 32'(bus.diff), 32'(mout[W-1:0]));
        chk("bout", 32'(bus.bout), 32'(mout[W]));
        chk("zero", 32'(bus.zero), 32'(mout[W+1]));
        chk("ovf", 32'(bus.ovf), 32'(mout[W+2]));
    end

    always @(posedge clk) begin
        if (rnd_mode) begin
            #2;
            bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Present operands, wait for acceptance; returns at accept edge + 2.
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
        int n = 0;
        bus.a = x;
        bus.b = y;
        bus.bin = bi;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 60) begin
            @(posedge clk); #2;
            n++;
        end
        if (!bus.in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: in_ready stuck at 0");
        end
        @(posedge clk); #2;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int l);
        l = 0;
        while (!bus.out_valid && l < 60) begin
            @(posedge clk); #2;
            l++;
        end
    endtask

    task automatic directed(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi,
                            input logic [W-1:0] ed, input logic eb, input logic eo,
                            input logic ez);
        int l;
        send(x, y, bi);
        wait_valid(l);
        chk("latency", 32'(l), 32'(NS));
        chk("lit_diff", 32'(bus.diff), 32'(ed));
        chk("lit_bout", 32'(bus.bout), 32'(eb));
        chk("lit_ovf", 32'(bus.ovf), 32'(eo));
        chk("lit_zero", 32'(bus.zero), 32'(ez));
        @(posedge clk); #2;
        chk("ready_after_hs", 32'(bus.in_ready), 32'd1);
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] v;
        case ($urandom_range(0, 5))
            0:       v = '0;
            1:       v = 16'hFFFF;
            2:       v = 16'h8000;
            3:       v = 16'h7FFF;
            default: v = 16'($urandom);
        endcase
        return v;
    endfunction

    initial begin
        int l;
        int last_acc;
        int nacc;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.bin       = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_diff", 32'(bus.diff), 32'd0);
        rst = 1'b0;
        #1;
        chk("rel_in_ready", 32'(bus.in_ready), 32'd1);

        directed(16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 1'b0, 1'b0);
        directed(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        directed(16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        directed(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
        directed(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0);
        directed(16'h5555, 16'h5554, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);

        // Backpressure, with a stray in_valid while the result is held.
        bus.out_ready = 1'b0;
        send(16'hABCD, 16'h1234, 1'b0);
        wait_valid(l);
        chk("bp_latency", 32'(l), 32'(NS));
        for (int i = 0; i < 3; i++) begin
            bus.a = 16'h0F00;
            bus.b = 16'h0001;
            bus.in_valid = 1'b1;
            @(posedge clk); #2;
            chk("bp_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_diff", 32'(bus.diff), 32'h9999);
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #2;
        chk("bp_release_ready", 32'(bus.in_ready), 32'd1);

        // Back-to-back with in_valid held high: accepts must be NS+2 cycles apart.
        bus.a = 16'h0F0F;
        bus.b = 16'h00FF;
        bus.bin = 1'b0;
        bus.in_valid = 1'b1;
        last_acc = -1;
        nacc = 0;
        for (int cyc = 0; cyc < 40 && nacc < 4; cyc++) begin
            if (bus.in_ready) begin
                if (last_acc >= 0) chk("init_interval", 32'(cyc - last_acc), 32'(NS + 2));
                last_acc = cyc;
                nacc++;
            end
            @(posedge clk); #2;
        end
        bus.in_valid = 1'b0;
        chk("b2b_accepts", 32'(nacc), 32'd4);
        repeat (8) @(posedge clk);
        #2;

        // Reset after slice 2 aborts the operation.
        send(16'h4321, 16'h1234, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("mrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mrst_diff", 32'(bus.diff), 32'd0);
        chk("mrst_bout", 32'(bus.bout), 32'd0);
        chk("mrst_in_ready", 32'(bus.in_ready), 32'd1);
        directed(16'hFFFF, 16'h0001, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0);

        // Randomized traffic with random backpressure; the model checks every cycle.
        rnd_mode = 1'b1;
        for (int i = 0; i < 40; i++) begin
            send(pick(), pick(), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 8)) @(posedge clk);
                #2;
            end
        end
        rnd_mode = 1'b0;
        @(posedge clk); #3;
        bus.out_ready = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
